// File: rtl/fp_io_pkg.sv
// Shared types and sizing helpers for the FP serial front end and core.
package fp_io_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SEND
    } state_t;

    function automatic int beats_f(input int fp_w, input int data_w);
        return fp_w / data_w;
    endfunction

    function automatic int cnt_w_f(input int beats);
        return $clog2(2 * beats);
    endfunction

endpackage

// File: rtl/fp_io_shreg.sv
// Word shift register with parallel load/read; the shift direction follows
// the word order so the first serial word ends up in its own slot.
module fp_io_shreg
    import fp_io_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BEATS     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [DATA_W*BEATS-1:0] i_pdata,
    input  logic                    i_shift,
    input  logic [DATA_W-1:0]       i_sdata,
    output logic [DATA_W*BEATS-1:0] o_pdata,
    output logic [DATA_W*BEATS-1:0] o_pnext,
    output logic [DATA_W-1:0]       o_sdata
);

    localparam int W = DATA_W * BEATS;

    logic [W-1:0] r_data;
    logic [W-1:0] w_next;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign w_next  = {r_data[W-DATA_W-1:0], i_sdata};
            assign o_sdata = r_data[W-1 -: DATA_W];
        end else begin : g_lsb
            assign w_next  = {i_sdata, r_data[W-1:DATA_W]};
            assign o_sdata = r_data[DATA_W-1:0];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_data <= '0;
        else if (i_load)
            r_data <= i_pdata;
        else if (i_shift)
            r_data <= w_next;
    end

    assign o_pdata = r_data;
    assign o_pnext = w_next;

endmodule

// File: rtl/fp_serial_io.sv
// Serial operand loader / result sender between the chip bus and the FP
// multiplier core. Operands are staged and only published once complete.
module fp_serial_io
    import fp_io_pkg::*;
#(
    parameter int FP_W      = 64,
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              READY,
    output logic              BUSY,
    output logic              ABORT,
    output logic              OVERRUN,
    output logic [FP_W-1:0]   OP_A,
    output logic [FP_W-1:0]   OP_B,
    output logic              OP_VALID,
    input  logic [FP_W-1:0]   RES,
    input  logic              RES_VALID
);

    localparam int BEATS = beats_f(FP_W, DATA_W);
    localparam int CW    = cnt_w_f(BEATS);

    localparam logic [CW-1:0] HALF   = CW'(BEATS);
    localparam logic [CW-1:0] LAST_L = CW'(2 * BEATS - 1);
    localparam logic [CW-1:0] LAST_S = CW'(BEATS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [FP_W-1:0] r_op_a;
    logic [FP_W-1:0] r_op_b;
    logic            r_op_valid;
    logic            r_abort;
    logic            r_ovr;

    logic w_a_shift;
    logic w_b_shift;
    logic w_op_load;
    logic w_res_load;
    logic w_res_shift;
    logic w_abort_nxt;
    logic w_ovr_nxt;

    logic [FP_W-1:0]   w_a_par;
    logic [FP_W-1:0]   w_b_next;
    logic [DATA_W-1:0] w_res_word;

    logic [FP_W-1:0]   w_unused_a_next;
    logic [DATA_W-1:0] w_unused_a_word;
    logic [FP_W-1:0]   w_unused_b_par;
    logic [DATA_W-1:0] w_unused_b_word;
    logic [FP_W-1:0]   w_unused_r_par;
    logic [FP_W-1:0]   w_unused_r_next;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_a_shift   = 1'b0;
        w_b_shift   = 1'b0;
        w_op_load   = 1'b0;
        w_res_load  = 1'b0;
        w_res_shift = 1'b0;
        w_abort_nxt = 1'b0;
        w_ovr_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (ENABLE) begin
                    w_a_shift   = 1'b1;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ENABLE) begin
                    w_a_shift = (r_cnt < HALF);
                    w_b_shift = (r_cnt >= HALF);
                    if (r_cnt == LAST_L) begin
                        w_op_load   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else begin
                    // a gap mid-load abandons the whole transaction
                    w_abort_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                w_ovr_nxt = ENABLE;
                if (RES_VALID) begin
                    w_res_load  = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                w_ovr_nxt   = ENABLE;
                w_res_shift = 1'b1;
                if (r_cnt == LAST_S) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // B is published from its shift-in view because its last word lands now
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_valid <= 1'b0;
            r_abort    <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            if (w_op_load) begin
                r_op_a <= w_a_par;
                r_op_b <= w_b_next;
            end
            r_op_valid <= w_op_load;
            r_abort    <= w_abort_nxt;
            r_ovr      <= w_ovr_nxt;
        end
    end

    fp_io_shreg #(
        .DATA_W    (DATA_W),
        .BEATS     (BEATS),
        .MSB_FIRST (MSB_FIRST)
    ) u_sh_a (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_load  (1'b0),
        .i_pdata ('0),
        .i_shift (w_a_shift),
        .i_sdata (DATA_IN),
        .o_pdata (w_a_par),
        .o_pnext (w_unused_a_next),
        .o_sdata (w_unused_a_word)
    );

    fp_io_shreg #(
        .DATA_W    (DATA_W),
        .BEATS     (BEATS),
        .MSB_FIRST (MSB_FIRST)
    ) u_sh_b (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_load  (1'b0),
        .i_pdata ('0),
        .i_shift (w_b_shift),
        .i_sdata (DATA_IN),
        .o_pdata (w_unused_b_par),
        .o_pnext (w_b_next),
        .o_sdata (w_unused_b_word)
    );

    fp_io_shreg #(
        .DATA_W    (DATA_W),
        .BEATS     (BEATS),
        .MSB_FIRST (MSB_FIRST)
    ) u_sh_res (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_load  (w_res_load),
        .i_pdata (RES),
        .i_shift (w_res_shift),
        .i_sdata ('0),
        .o_pdata (w_unused_r_par),
        .o_pnext (w_unused_r_next),
        .o_sdata (w_res_word)
    );

    assign READY    = (r_state == S_SEND);
    assign BUSY     = (r_state != S_IDLE);
    assign DATA_OUT = READY ? w_res_word : '0;
    assign ABORT    = r_abort;
    assign OVERRUN  = r_ovr;
    assign OP_A     = r_op_a;
    assign OP_B     = r_op_b;
    assign OP_VALID = r_op_valid;

endmodule

// File: doc/fp_serial_io.md
# fp_serial_io

Parametrised serial front end for the floating-point multiplier datapath. It deserialises two FP_W-bit operands arriving as DATA_W-bit words on a single-clock serial bus and hands them to the arithmetic core with a valid pulse. It then waits for the core's result and serialises it back out under a READY strobe. It replaces the fixed 8-bit / 64-bit / LSB-first chip I/O with configurable width, word order, abort handling and overrun signalling.

## Interface
- FP_W, 64: operand/result width in bits; must be a multiple of DATA_W.
- DATA_W, 8: serial bus width in bits.
- MSB_FIRST, 0: 0 = least-significant word first on both input and output; 1 = most-significant word first.
- BEATS, FP_W/DATA_W (derived, not overridable): words per operand or result.
- CLK  in  1  single clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  input word qualifier; high = DATA_IN valid this cycle.
- DATA_IN  in  DATA_W  serial operand word.
- DATA_OUT  out  DATA_W  serial result word; 0 when READY is low.
- READY  out  1  high for exactly BEATS consecutive cycles, one result word per cycle.
- BUSY  out  1  high from the first accepted word until the last result beat.
- ABORT  out  1  one-cycle pulse when a load is abandoned.
- OVERRUN  out  1  one-cycle pulse when ENABLE is high while waiting for the core or sending.
- OP_A, OP_B  out  FP_W  assembled operands; held stable from OP_VALID until the next load starts.
- OP_VALID  out  1  one-cycle pulse when operands are complete.
- RES  in  FP_W  core result.
- RES_VALID  in  1  core result qualifier; sampled only in WAIT.

## Operation
- States: IDLE, LOAD, WAIT, SEND.
- IDLE: ENABLE high captures DATA_IN as word 0 of A, sets the word counter to 1 and moves to LOAD. ENABLE low: stay in IDLE.
- LOAD: each cycle with ENABLE high captures one word.
  - Counter 0..BEATS-1 fills A; BEATS..2*BEATS-1 fills B.
  - Word k of an operand lands in bits [k*DATA_W +: DATA_W], or the mirrored slot when MSB_FIRST=1.
  - After word 2*BEATS-1: pulse OP_VALID next cycle and move to WAIT.
- Abort: ENABLE low in LOAD before all words have arrived pulses ABORT, discards the partial operands (OP_A/OP_B unchanged), clears the counter and returns to IDLE. Gaps are not allowed.
- WAIT: on RES_VALID, latch RES into the output shift register and move to SEND. RES_VALID outside WAIT is ignored. There is no timeout.
- SEND: drive BEATS words from the latched result, in the same order rule as the input. READY is high throughout. After the last beat, return to IDLE.
- Any ENABLE high in WAIT or SEND pulses OVERRUN and the word is dropped. The transaction in progress is unaffected.
- Counter width is $clog2(2*BEATS). The counter saturates at no point; it is cleared on every return to IDLE.
- Reset at any point: state IDLE, counter 0, all outputs 0 (DATA_OUT, READY, BUSY, ABORT, OVERRUN, OP_VALID, OP_A, OP_B). The next ENABLE starts a fresh load.

## Timing
- Input: word i is sampled at the rising edge where ENABLE=1. The word sent in the cycle after the last B word may start a new load only after the transaction returns to IDLE.
- OP_VALID is registered: high in the cycle after the edge that captured the last word.
- Core latency is arbitrary, at least 1 cycle after OP_VALID.
- READY rises on the edge after RES_VALID is sampled. The first result word is valid in the same cycle READY rises. READY stays high BEATS cycles, then falls, and BUSY falls with it.
- End-to-end minimum: 2*BEATS load cycles + 1 (OP_VALID) + core latency + 1 + BEATS.
- The earliest new load is the cycle immediately after the last READY cycle.

## Structure
- Package fp_io_pkg holds the state enum and the beat-count and counter-width helper functions. The multiplier core shares this package.
- One natural sub-module, fp_io_shreg: a parametrised DATA_W×BEATS shift register with parallel load and parallel read, plus a word-order mode. It is instantiated three times: A, B, and the result.

## Test plan
- Default params: A=0x3FF8000000000000, B=0x4000000000000000, core model returns 0x4008000000000000 after 3 cycles -> OP_VALID once; READY high 8 cycles; DATA_OUT = 00,00,00,00,00,00,08,40.
- DATA_W=16, MSB_FIRST=1: A=0x7FF0000000000000 sent as 7FF0,0000,0000,0000 -> OP_A=0x7FF0000000000000; result 0x7FF8000000000000 -> READY high 4 cycles with 7FF8,0000,0000,0000.
- ENABLE drops after 5 words -> ABORT pulses once, no OP_VALID, BUSY low next cycle; the following 16-word load completes normally.
- ENABLE high for 2 cycles during WAIT -> OVERRUN pulses twice; the result is still sent intact and unchanged.
- RESET asserted in the 3rd READY cycle -> all outputs 0 next cycle; RES_VALID pulsed in IDLE is ignored.
- RES_VALID asserted during LOAD -> ignored; the core model's later RES_VALID in WAIT produces the result.
